// File: rtl/doubleword_normalizer_if.sv
// Operand/result bundle for the doubleword normalizer.
// master drives operands and out_ready; slave is the normalizer itself.
interface doubleword_normalizer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              data_tc;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  norm_cnt;
    logic [DATA_W-1:0] data_norm;
    logic              is_zero;

    modport master (
        output in_valid, data_in, data_tc, out_ready,
        input  in_ready, out_valid, norm_cnt, data_norm, is_zero
    );

    modport slave (
        input  in_valid, data_in, data_tc, out_ready,
        output in_ready, out_valid, norm_cnt, data_norm, is_zero
    );
endinterface

// File: rtl/doubleword_normalizer.sv
// Two-stage 64-bit normalizer: leading-zero / redundant-sign count plus left-justify.
// Stage 1 counts whole matching groups, stage 2 finishes the count and shifts.
module doubleword_normalizer #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 7,
    parameter int GRP_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    doubleword_normalizer_if.slave bus
);
    localparam int NGRP = DATA_W / GRP_W;
    localparam int GC_W = $clog2(NGRP + 1);

    // Handshake: a word moves on valid & ready at the rising edge. A producer
    // holds valid and payload until ready; out_valid and the result stay put
    // until out_ready. in_ready never looks at in_valid.
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_tc;
    logic [GC_W-1:0]   s1_coarse;

    logic              out_valid_q;
    logic [CNT_W-1:0]  norm_cnt_q;
    logic [DATA_W-1:0] data_norm_q;
    logic              is_zero_q;

    logic adv2;
    logic in_xfer;

    assign adv2         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || adv2;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.norm_cnt  = norm_cnt_q;
    assign bus.data_norm = data_norm_q;
    assign bus.is_zero   = is_zero_q;

    // Stage 1: leading groups equal to the fill bit (0 unsigned, bit 63 signed).
    logic [GC_W-1:0]  coarse;
    logic             s1_stop;
    logic             fill_in;
    logic [GRP_W-1:0] grp;

    always_comb begin
        coarse  = '0;
        s1_stop = 1'b0;
        grp     = '0;
        fill_in = bus.data_tc & bus.data_in[DATA_W-1];
        for (int g = 0; g < NGRP; g++) begin
            grp = bus.data_in[DATA_W-1-g*GRP_W -: GRP_W];
            if (!s1_stop && (grp == {GRP_W{fill_in}})) begin
                coarse = coarse + GC_W'(1);
            end else begin
                s1_stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_tc     <= 1'b0;
            s1_coarse <= '0;
        end else if (in_xfer) begin
            s1_valid  <= 1'b1;
            s1_data   <= bus.data_in;
            s1_tc     <= bus.data_tc;
            s1_coarse <= coarse;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: fine count inside the first non-matching group, then shift.
    logic              fill_s1;
    logic [CNT_W-1:0]  base;
    logic [DATA_W-1:0] grp_aligned;
    logic [GRP_W-1:0]  top;
    logic [CNT_W-1:0]  fine;
    logic              s2_stop;
    logic              all_fill;
    logic [CNT_W-1:0]  lead;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] norm_next;

    always_comb begin
        fill_s1     = s1_tc & s1_data[DATA_W-1];
        base        = CNT_W'(s1_coarse) * CNT_W'(GRP_W);
        grp_aligned = s1_data << base;
        top         = grp_aligned[DATA_W-1 -: GRP_W];
        fine        = '0;
        s2_stop     = 1'b0;
        for (int b = GRP_W - 1; b >= 0; b--) begin
            if (!s2_stop && (top[b] == fill_s1)) begin
                fine = fine + CNT_W'(1);
            end else begin
                s2_stop = 1'b1;
            end
        end
        all_fill = (s1_coarse == GC_W'(NGRP));
        lead     = all_fill ? CNT_W'(DATA_W) : (base + fine);
        // The sign bit itself is not redundant, so signed mode counts one less.
        cnt_next  = s1_tc ? (lead - CNT_W'(1)) : lead;
        norm_next = s1_data << cnt_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            norm_cnt_q  <= '0;
            data_norm_q <= '0;
            is_zero_q   <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                norm_cnt_q  <= cnt_next;
                data_norm_q <= norm_next;
                is_zero_q   <= all_fill;
            end
        end
    end
endmodule

// File: tb/tb_doubleword_normalizer.sv
// Bench for doubleword_normalizer: bit-walk reference model, per-cycle scoreboard,
// directed literal vectors, backpressure, full-rate and reset-in-flight scenarios.
module tb_doubleword_normalizer;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 7;
    localparam int RES_W  = CNT_W + DATA_W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    doubleword_normalizer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    doubleword_normalizer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GRP_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int res_idx = 0;
    logic [RES_W-1:0] exp_q[$];

    // Reference: walk bits from the MSB, count those equal to the fill bit.
    function automatic logic [RES_W-1:0] ref_norm(input logic [63:0] d, input logic tc);
        int lead;
        int cnt;
        logic fill;
        logic [63:0] dn;
        logic zero;
        lead = 0;
        fill = tc ? d[63] : 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (d[i] == fill) lead++;
            else break;
        end
        cnt  = tc ? lead - 1 : lead;
        dn   = (cnt >= 64) ? 64'd0 : (d << cnt);
        zero = (lead == 64);
        return {cnt[CNT_W-1:0], dn, zero};
    endfunction

    function automatic logic [RES_W-1:0] dut_res();
        return {bus.norm_cnt, bus.data_norm, bus.is_zero};
    endfunction

    task automatic check_res(input string name, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d data=%h zero=%b, required cnt=%0d data=%h zero=%b",
                     name, got[RES_W-1 -: CNT_W], got[DATA_W:1], got[0],
                     exp[RES_W-1 -: CNT_W], exp[DATA_W:1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Scoreboard: sample between edges, pop on output transfer, push on input transfer.
    logic stall_armed = 1'b0;
    logic [RES_W-1:0] stall_val;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall_armed = 1'b0;
        end else begin
            if (stall_armed) begin
                check_val("stall_valid_hold", 64'(bus.out_valid), 64'd1);
                check_res("stall_data_hold", dut_res(), stall_val);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got out_valid=1, required no pending result");
                end else begin
                    check_res($sformatf("result[%0d]", res_idx), dut_res(), exp_q.pop_front());
                end
                res_idx++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_norm(bus.data_in, bus.data_tc));
            stall_armed = bus.out_valid && !bus.out_ready;
            stall_val   = dut_res();
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
    endtask

    task automatic directed(input string name, input logic [63:0] d, input logic tc,
                            input logic [6:0] ecnt, input logic [63:0] edata, input logic ezero);
        check_res({name, "_model"}, ref_norm(d, tc), {ecnt, edata, ezero});
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.data_tc   = tc;
        check_val({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_res(name, dut_res(), {ecnt, edata, ezero});
        idle(2);
    endtask

    task automatic rand_op(output logic [63:0] d, output logic tc);
        d  = {$urandom, $urandom} >> $urandom_range(0, 64);
        tc = 1'($urandom_range(0, 1));
        if (tc && ($urandom_range(0, 1) == 1)) d = ~d;
    endtask

    task automatic backpressure();
        logic [63:0] v[4];
        logic t[4];
        int sent;
        v[0] = 64'h0000_00F0_0000_0000; t[0] = 1'b0;
        v[1] = 64'hFFFF_8000_0000_1234; t[1] = 1'b1;
        v[2] = 64'h0000_0000_0000_0003; t[2] = 1'b1;
        v[3] = 64'h0123_4567_89AB_CDEF; t[3] = 1'b0;
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = (c >= 5);
            bus.in_valid  = (sent < 4);
            bus.data_in   = v[(sent < 4) ? sent : 0];
            bus.data_tc   = t[(sent < 4) ? sent : 0];
            if (c >= 2 && c <= 4) begin
                check_val($sformatf("bp_in_ready[%0d]", c), 64'(bus.in_ready), 64'd0);
                check_val($sformatf("bp_accepted[%0d]", c), 64'(sent), 64'd2);
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check_val("bp_total_sent", 64'(sent), 64'd4);
        idle(3);
    endtask

    task automatic throughput();
        logic [63:0] d;
        logic tc;
        for (int i = 0; i < 104; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            if (i < 100) begin
                rand_op(d, tc);
                bus.in_valid = 1'b1;
                bus.data_in  = d;
                bus.data_tc  = tc;
                check_val($sformatf("tput_in_ready[%0d]", i), 64'(bus.in_ready), 64'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            check_val($sformatf("tput_out_valid[%0d]", i), 64'(bus.out_valid),
                      64'((i >= 2) && (i < 102)));
        end
        idle(2);
    endtask

    task automatic reset_in_flight();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 64'h0000_0000_1000_0000;
        bus.data_tc   = 1'b0;
        @(posedge clk);
        #1;
        bus.data_in = 64'hFFFF_FFFF_0000_0000;
        bus.data_tc = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_flight_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_flight_in_ready", 64'(bus.in_ready), 64'd1);
        check_res("rst_flight_outputs", dut_res(), '0);
        directed("post_reset_first", 64'h0000_0000_0000_00FF, 1'b0, 7'd56, 64'hFF00_0000_0000_0000, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.data_tc   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check_res("reset_outputs", dut_res(), '0);

        directed("u_bit16",     64'h0000_0000_0001_0000, 1'b0, 7'd47, 64'h8000_0000_0000_0000, 1'b0);
        directed("u_zero",      64'h0000_0000_0000_0000, 1'b0, 7'd64, 64'h0000_0000_0000_0000, 1'b1);
        directed("u_msb",       64'h8000_0000_0000_0000, 1'b0, 7'd0,  64'h8000_0000_0000_0000, 1'b0);
        directed("u_one",       64'h0000_0000_0000_0001, 1'b0, 7'd63, 64'h8000_0000_0000_0000, 1'b0);
        directed("u_grp_edge",  64'h0000_8000_0000_0000, 1'b0, 7'd16, 64'h8000_0000_0000_0000, 1'b0);
        directed("s_all_ones",  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd63, 64'h8000_0000_0000_0000, 1'b1);
        directed("s_all_zero",  64'h0000_0000_0000_0000, 1'b1, 7'd63, 64'h0000_0000_0000_0000, 1'b1);
        directed("s_neg_f000",  64'hFFFF_FFFF_FFFF_F000, 1'b1, 7'd51, 64'h8000_0000_0000_0000, 1'b0);
        directed("s_one",       64'h0000_0000_0000_0001, 1'b1, 7'd62, 64'h4000_0000_0000_0000, 1'b0);
        directed("s_max_pos",   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 7'd0,  64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        directed("s_c000",      64'hC000_0000_0000_0000, 1'b1, 7'd1,  64'h8000_0000_0000_0000, 1'b0);

        backpressure();
        throughput();
        reset_in_flight();

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        check_val("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
